spi_tx_scheduler: RTL

SPI_TX_SCHEDULER -- requirements
Module: spi_tx_scheduler

---
 rtl/spi_tx_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler: round-robin byte scheduler for two requesters in front of an SPI master.
// Optional WAIT-state watchdog: define SPI_TIMEOUT_EN to enable the abort path and the ERR flag.
module spi_tx_scheduler #(
  parameter int INIT_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic       CLK_1KHZ,
  input  logic       RESET_N,
  input  logic       REQ_A,
  input  logic [7:0] DATA_A,
  output logic       ACK_A,
  input  logic       REQ_B,
  input  logic [7:0] DATA_B,
  output logic       ACK_B,
  input  logic       SPI_DONE,
  output logic [7:0] SPI_DATA,
  output logic       SPI_START,
  output logic       SPI_RESET,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  localparam logic [7:0] LP_INIT_LAST = 8'(INIT_CYCLES - 1);

  generate
    if (INIT_CYCLES < 1 || INIT_CYCLES > 15) begin : g_bad_init
      $error("spi_tx_scheduler: INIT_CYCLES must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("spi_tx_scheduler: TIMEOUT_CYCLES must be 1..255");
    end
  endgenerate

  state_t     r_state, w_state_nx;
  logic [7:0] r_cnt, w_cnt_nx;
  logic       r_last_b, w_last_b_nx;   // last requester served (or aborted) was B
  logic       r_gnt_b, w_gnt_b_nx;     // requester owning the current transfer is B
  logic [7:0] r_data, w_data_nx;
  logic       r_start, w_start_nx;
  logic       r_spi_rst, w_spi_rst_nx;
  logic       r_ack_a, w_ack_a_nx;
  logic       r_ack_b, w_ack_b_nx;
  logic       r_busy, w_busy_nx;
  logic       w_pick_b;

`ifdef SPI_TIMEOUT_EN
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic r_err, w_err_nx;
`endif

  // On a tie the requester that was not served last wins.
  assign w_pick_b = REQ_B && (!REQ_A || !r_last_b);

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_last_b_nx  = r_last_b;
    w_gnt_b_nx   = r_gnt_b;
    w_data_nx    = r_data;
    w_start_nx   = 1'b0;
    w_spi_rst_nx = r_spi_rst;
    w_ack_a_nx   = 1'b0;
    w_ack_b_nx   = 1'b0;
    w_busy_nx    = r_busy;
`ifdef SPI_TIMEOUT_EN
    w_err_nx     = r_err;
`endif
    case (r_state)
      ST_INIT: begin
        w_spi_rst_nx = 1'b1;
        w_busy_nx    = 1'b1;
        if (r_cnt == LP_INIT_LAST) begin
          w_state_nx   = ST_IDLE;
          w_spi_rst_nx = 1'b0;
          w_busy_nx    = 1'b0;
          w_cnt_nx     = 8'd0;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      ST_IDLE: begin
        w_busy_nx = 1'b0;
        if (REQ_A || REQ_B) begin
          w_gnt_b_nx = w_pick_b;
          w_data_nx  = w_pick_b ? DATA_B : DATA_A;
          w_start_nx = 1'b1;
          w_busy_nx  = 1'b1;
          w_cnt_nx   = 8'd0;
          w_state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A DONE arriving together with our own START belongs to an older transfer.
        if (!r_start && SPI_DONE) begin
          w_state_nx  = ST_ACK;
          w_ack_a_nx  = !r_gnt_b;
          w_ack_b_nx  = r_gnt_b;
          w_last_b_nx = r_gnt_b;
          w_cnt_nx    = 8'd0;
        end
`ifdef SPI_TIMEOUT_EN
        else if (r_cnt == LP_TO_LAST) begin
          // Abort: skip the stuck requester next time and reset the master.
          w_state_nx   = ST_INIT;
          w_err_nx     = 1'b1;
          w_last_b_nx  = r_gnt_b;
          w_spi_rst_nx = 1'b1;
          w_cnt_nx     = 8'd0;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
`endif
      end
      ST_ACK: begin
        w_state_nx = ST_IDLE;
        w_busy_nx  = 1'b0;
      end
      default: begin
        w_state_nx   = ST_INIT;
        w_spi_rst_nx = 1'b1;
        w_busy_nx    = 1'b1;
        w_cnt_nx     = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK_1KHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_INIT;
      r_cnt     <= 8'd0;
      r_last_b  <= 1'b1;
      r_gnt_b   <= 1'b0;
      r_data    <= 8'd0;
      r_start   <= 1'b0;
      r_spi_rst <= 1'b1;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_busy    <= 1'b1;
`ifdef SPI_TIMEOUT_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_last_b  <= w_last_b_nx;
      r_gnt_b   <= w_gnt_b_nx;
      r_data    <= w_data_nx;
      r_start   <= w_start_nx;
      r_spi_rst <= w_spi_rst_nx;
      r_ack_a   <= w_ack_a_nx;
      r_ack_b   <= w_ack_b_nx;
      r_busy    <= w_busy_nx;
`ifdef SPI_TIMEOUT_EN
      r_err     <= w_err_nx;
`endif
    end
  end

  assign ACK_A     = r_ack_a;
  assign ACK_B     = r_ack_b;
  assign SPI_DATA  = r_data;
  assign SPI_START = r_start;
  assign SPI_RESET = r_spi_rst;
  assign BUSY      = r_busy;
`ifdef SPI_TIMEOUT_EN
  assign ERR       = r_err;
`else
  assign ERR       = 1'b0;
`endif

  a_ack_exclusive: assert property (@(posedge CLK_1KHZ) disable iff (!RESET_N)
    !(r_ack_a && r_ack_b));
  a_start_single: assert property (@(posedge CLK_1KHZ) disable iff (!RESET_N)
    r_start |=> !r_start);

endmodule
